seg_counter_ctrl: RTL and testbench
===================================

SEG_COUNTER_CTRL -- requirements
Module: seg_counter_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, 4, consecutive stable synchronized samples required to accept a button level change.
REQ-002 Parameter SCAN_CYCLES, 8, clock cycles each digit stays enabled.
REQ-003 Parameter REPEAT_CYCLES, 16, hold cycles between auto-repeat steps (used only with SEG_AUTO_REPEAT_EN).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 b_up  input  1  raw asynchronous increment button, active-high.
REQ-007 b_dn  input  1  raw asynchronous decrement button, active-high.
REQ-008 seg  output  7  segment drive, seg[6:0] = g,f,e,d,c,b,a, active-low.
REQ-009 dp  output  1  decimal point, active-low, constant 1 (off).
REQ-010 an  output  2  digit enables, active-low; an[0] = units, an[1] = tens.
REQ-011 count  output  8  current value as BCD {tens[7:4], units[3:0]}.

Function
REQ-012 Each button SHALL pass through a two-flop synchronizer before debounce.
REQ-013 Debounce FSM per button SHALL have states IDLE, ARMING, HELD, RELEASING.
REQ-014 Transitions: IDLE->ARMING on sync high; ARMING->HELD after DEB_CYCLES consecutive highs, ARMING->IDLE on any low; HELD->RELEASING on sync low; RELEASING->IDLE after DEB_CYCLES consecutive lows, RELEASING->HELD on any high.
REQ-015 A one-cycle press pulse SHALL be produced on the ARMING->HELD transition only.
REQ-016 Latency: with raw input rising before edge 0 and held stable, count SHALL update on edge DEB_CYCLES+3.
REQ-017 Up pulse: units 9->0 with carry to tens; 99 wraps to 00.
REQ-018 Down pulse: units 0->9 with borrow from tens; 00 wraps to 99.
REQ-019 Up and down pulses in the same cycle SHALL cancel; count unchanged.
REQ-020 Scan counter SHALL run 0..SCAN_CYCLES-1 freely; the selected digit SHALL toggle on wrap.
REQ-021 Exactly one an bit SHALL be low at any time; seg and an SHALL be registered and change on the same edge.
REQ-022 Patterns (hex, seg[6:0]): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; any other nibble = 7F (blank).
REQ-023 Tens digit SHALL display leading zero (no blanking).
REQ-024 Count update and scan SHALL be independent; seg SHALL reflect a new count within one scan slot.

Reset
REQ-025 On rst_n low: count=8'h00, an=2'b10, seg=7'h40, dp=1, both FSMs IDLE, all counters and synchronizers 0.
REQ-026 Reset asserted mid-press SHALL abort the press with no count change.
REQ-027 A button held across reset release SHALL be treated as a new press and counted once after debounce.

Configuration
REQ-028 With SEG_AUTO_REPEAT_EN defined, in HELD a repeat counter SHALL issue an extra press pulse every REPEAT_CYCLES cycles, restarting on each entry to HELD.
REQ-029 Without SEG_AUTO_REPEAT_EN, exactly one pulse per press SHALL be issued, and no repeat counter SHALL exist.

Structure
REQ-030 Package seg_pkg SHALL hold the debounce state enum, the 10-entry segment table, and SEG_BLANK=7'h7F.
REQ-031 Sub-module btn_debounce (synchronizer, FSM, pulse, optional repeat) SHALL be instantiated twice.

Verification (DEB_CYCLES=4, SCAN_CYCLES=8, REPEAT_CYCLES=16)
REQ-032 Reset, then 10 presses of b_up (10 cycles high, 10 low) -> count steps 01..09, ends 8'h10.
REQ-033 b_up high 3 cycles then low -> count unchanged, no pulse.
REQ-034 From 00, one b_dn press -> 8'h99; then one b_up press -> 8'h00.
REQ-035 b_up and b_dn rise on the same edge and are held 10 cycles -> count unchanged.
REQ-036 count=8'h42 -> an alternates 2'b10/2'b01 every 8 cycles; seg=7'h24 when an=2'b10, seg=7'h19 when an=2'b01.
REQ-037 b_up held 50 cycles from 00 -> 8'h03 with macro (steps at edges 7, 23, 39), 8'h01 without.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types, segment table and BCD helpers for the two-digit counter.
// Optional feature macro: SEG_AUTO_REPEAT_EN (auto-repeat while held).
package seg_pkg;

   typedef enum logic [1:0] {
      DEB_IDLE,
      DEB_ARMING,
      DEB_HELD,
      DEB_RELEASING
   } deb_state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // seg[6:0] = g,f,e,d,c,b,a, active-low
   localparam logic [6:0] SEG_TABLE [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] p;
      p = SEG_BLANK;
      if (d < 4'd10) p = SEG_TABLE[d];
      return p;
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [3:0] t;
      logic [3:0] u;
      t = v[7:4];
      u = v[3:0];
      if (u == 4'd9) begin
         u = 4'd0;
         t = (t == 4'd9) ? 4'd0 : t + 4'd1;
      end else begin
         u = u + 4'd1;
      end
      return {t, u};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      logic [3:0] t;
      logic [3:0] u;
      t = v[7:4];
      u = v[3:0];
      if (u == 4'd0) begin
         u = 4'd9;
         t = (t == 4'd0) ? 4'd9 : t - 4'd1;
      end else begin
         u = u - 4'd1;
      end
      return {t, u};
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer + debounce FSM producing a one-cycle press pulse.
// SEG_AUTO_REPEAT_EN adds periodic extra pulses while the button is held.
module btn_debounce
   import seg_pkg::*;
#(
   parameter int DEB_CYCLES    = 4,
   parameter int REPEAT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          lvl;
   deb_state_e    state_q, state_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic          arm_fire;
   logic          rep_fire;
   logic          press_q, press_d;

   assign lvl = sync_q[1];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      arm_fire = 1'b0;
      unique case (state_q)
         DEB_IDLE: begin
            if (lvl) begin
               state_d = DEB_ARMING;
               cnt_d   = '0;
            end
         end
         DEB_ARMING: begin
            if (!lvl) begin
               state_d = DEB_IDLE;
            end else if (cnt_q == DEB_LAST) begin
               state_d  = DEB_HELD;
               arm_fire = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DEB_HELD: begin
            if (!lvl) begin
               state_d = DEB_RELEASING;
               cnt_d   = '0;
            end
         end
         DEB_RELEASING: begin
            if (lvl) begin
               state_d = DEB_HELD;
            end else if (cnt_q == DEB_LAST) begin
               state_d = DEB_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = DEB_IDLE;
      endcase
   end

`ifdef SEG_AUTO_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rep_q, rep_d;

   // restarts from zero on every entry to HELD
   always_comb begin
      rep_d    = '0;
      rep_fire = 1'b0;
      if (state_q == DEB_HELD) begin
         if (rep_q == REP_LAST) begin
            rep_fire = 1'b1;
         end else begin
            rep_d = rep_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rep_q <= '0;
      else        rep_q <= rep_d;
   end
`else
   assign rep_fire = (REPEAT_CYCLES < 0);
`endif

   assign press_d = arm_fire | rep_fire;
   assign press   = press_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         state_q <= DEB_IDLE;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

endmodule

// File: rtl/seg_counter_ctrl.sv
// Two-digit BCD up/down counter with debounced buttons and muxed 7-seg.
// SEG_AUTO_REPEAT_EN enables auto-repeat on held buttons.
module seg_counter_ctrl
   import seg_pkg::*;
#(
   parameter int DEB_CYCLES    = 4,
   parameter int SCAN_CYCLES   = 8,
   parameter int REPEAT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       b_up,
   input  logic       b_dn,
   output logic [6:0] seg,
   output logic       dp,
   output logic [1:0] an,
   output logic [7:0] count
);

   localparam int SW = $clog2(SCAN_CYCLES + 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

   logic          up_p, dn_p;
   logic [7:0]    count_q, count_d;
   logic [SW-1:0] scan_q, scan_d;
   logic          sel_q, sel_d;
   logic [1:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;

   btn_debounce #(
      .DEB_CYCLES    (DEB_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_up (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (b_up),
      .press (up_p)
   );

   btn_debounce #(
      .DEB_CYCLES    (DEB_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_dn (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (b_dn),
      .press (dn_p)
   );

   // simultaneous up and down cancel out
   always_comb begin
      count_d = count_q;
      unique case ({up_p, dn_p})
         2'b10:   count_d = bcd_inc(count_q);
         2'b01:   count_d = bcd_dec(count_q);
         default: count_d = count_q;
      endcase
   end

   // sel=0 drives units (an=10), sel=1 drives tens (an=01)
   always_comb begin
      scan_d = scan_q + 1'b1;
      sel_d  = sel_q;
      if (scan_q == SCAN_LAST) begin
         scan_d = '0;
         sel_d  = ~sel_q;
      end
      an_d  = sel_d ? 2'b01 : 2'b10;
      seg_d = seg_decode(sel_d ? count_q[7:4] : count_q[3:0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 8'h00;
         scan_q  <= '0;
         sel_q   <= 1'b0;
         an_q    <= 2'b10;
         seg_q   <= 7'h40;
      end else begin
         count_q <= count_d;
         scan_q  <= scan_d;
         sel_q   <= sel_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign count = count_q;
   assign an    = an_q;
   assign seg   = seg_q;
   assign dp    = 1'b1;

endmodule

// File: tb/tb_seg_counter_ctrl.sv
// Directed self-checking bench for seg_counter_ctrl (default parameters).
module tb_seg_counter_ctrl;

   logic       clk;
   logic       rst_n;
   logic       b_up;
   logic       b_dn;
   logic [6:0] seg;
   logic       dp;
   logic [1:0] an;
   logic [7:0] count;

   int checks = 0;
   int errors = 0;

   seg_counter_ctrl #(
      .DEB_CYCLES    (4),
      .SCAN_CYCLES   (8),
      .REPEAT_CYCLES (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .b_up  (b_up),
      .b_dn  (b_dn),
      .seg   (seg),
      .dp    (dp),
      .an    (an),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      b_up  = 1'b0;
      b_dn  = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
   endtask

   task automatic press(input logic up, input logic dn,
                        input int hi, input int lo);
      b_up = up;
      b_dn = dn;
      cyc(hi);
      b_up = 1'b0;
      b_dn = 1'b0;
      cyc(lo);
   endtask

   task automatic wait_an(output int n);
      logic [1:0] prev;
      prev = an;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (an == prev && n < 20);
   endtask

   initial begin
      int n;
      logic [7:0] exp;
      rst_n = 1'b0;
      b_up  = 1'b0;
      b_dn  = 1'b0;
      cyc(2);
      check("rst_count", 32'(count), 32'h00);
      check("rst_an", 32'(an), 32'h2);
      check("rst_seg", 32'(seg), 32'h40);
      check("rst_dp", 32'(dp), 32'h1);
      rst_n = 1'b1;
      cyc(1);

      // ten up presses: 01..09 then 10
      for (int i = 1; i <= 10; i++) begin
         press(1'b1, 1'b0, 10, 10);
         exp = (i < 10) ? 8'(i) : 8'h10;
         check("up_step", 32'(count), 32'(exp));
      end

      // glitch shorter than the debounce window
      press(1'b1, 1'b0, 3, 12);
      check("glitch", 32'(count), 32'h10);

      do_reset();
      press(1'b0, 1'b1, 10, 10);
      check("dn_wrap", 32'(count), 32'h99);
      press(1'b1, 1'b0, 10, 10);
      check("up_wrap", 32'(count), 32'h00);

      press(1'b1, 1'b1, 10, 10);
      check("cancel", 32'(count), 32'h00);

      repeat (42) press(1'b1, 1'b0, 10, 10);
      check("count42", 32'(count), 32'h42);
      wait_an(n);
      for (int k = 0; k < 2; k++) begin
         wait_an(n);
         check("slot_len", 32'(n), 32'd8);
      end
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         if (an == 2'b10) begin
            check("seg_units", 32'(seg), 32'h24);
         end else begin
            check("an_tens", 32'(an), 32'h1);
            check("seg_tens", 32'(seg), 32'h19);
         end
      end

      // reset aborts an in-flight press
      do_reset();
      b_up = 1'b1;
      cyc(5);
      rst_n = 1'b0;
      b_up  = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(12);
      check("abort", 32'(count), 32'h00);

      // held across reset release counts once
      rst_n = 1'b0;
      b_up  = 1'b1;
      cyc(2);
      rst_n = 1'b1;
      cyc(12);
      b_up = 1'b0;
      cyc(10);
      check("held_rst", 32'(count), 32'h01);
      cyc(20);
      check("held_rst2", 32'(count), 32'h01);

      // long hold: latency and auto-repeat
      do_reset();
      b_up = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 6) check("lat_e6", 32'(count), 32'h00);
         if (k == 7) check("lat_e7", 32'(count), 32'h01);
`ifdef SEG_AUTO_REPEAT_EN
         if (k == 22) check("rep_e22", 32'(count), 32'h01);
         if (k == 23) check("rep_e23", 32'(count), 32'h02);
         if (k == 39) check("rep_e39", 32'(count), 32'h03);
`else
         if (k == 23) check("rep_e23", 32'(count), 32'h01);
         if (k == 39) check("rep_e39", 32'(count), 32'h01);
`endif
      end
      b_up = 1'b0;
      cyc(12);
`ifdef SEG_AUTO_REPEAT_EN
      check("hold50", 32'(count), 32'h03);
`else
      check("hold50", 32'(count), 32'h01);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
